// File: rtl/bus_dec1to2.sv
// One-master to two-slave address decoder. Unmapped accesses and slaves that
// stall too long are terminated locally with ERR_DATA, and the first such error is held for debug.
`timescale 1ns/1ps
module bus_dec1to2 #(
    parameter logic [31:0] S0_BASE  = 32'h0000_0000,
    parameter logic [31:0] S0_MASK  = 32'hFFFF_0000,
    parameter logic [31:0] S1_BASE  = 32'h1000_0000,
    parameter logic [31:0] S1_MASK  = 32'hF000_0000,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m_valid,
    output logic        m_ready,
    input  logic [31:0] m_addr,
    output logic [31:0] m_rdata,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  m_wstrb,

    output logic        s0_valid,
    input  logic        s0_ready,
    output logic [31:0] s0_addr,
    input  logic [31:0] s0_rdata,
    output logic [31:0] s0_wdata,
    output logic [3:0]  s0_wstrb,

    output logic        s1_valid,
    input  logic        s1_ready,
    output logic [31:0] s1_addr,
    input  logic [31:0] s1_rdata,
    output logic [31:0] s1_wdata,
    output logic [3:0]  s1_wstrb,

    output logic        err_valid,
    output logic [31:0] err_addr,
    input  logic        err_clr
);

    localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL0 = 2'd1,
        SEL1 = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          hit0;
    logic          hit1;
    logic          sel_ready;
    logic [31:0]   sel_rdata;
    logic          sel_valid;
    logic          capture;

    assign hit0 = (m_addr & S0_MASK) == S0_BASE;
    assign hit1 = (m_addr & S1_MASK) == S1_BASE;

    // Request fields always pass through; only valid is steered.
    assign s0_addr  = m_addr;
    assign s0_wdata = m_wdata;
    assign s0_wstrb = m_wstrb;
    assign s1_addr  = m_addr;
    assign s1_wdata = m_wdata;
    assign s1_wstrb = m_wstrb;

    assign sel_ready = (state == SEL1) ? s1_ready : s0_ready;
    assign sel_rdata = (state == SEL1) ? s1_rdata : s0_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        m_ready   = 1'b0;
        m_rdata   = '0;
        sel_valid = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (m_valid) begin
                    if (hit0)      state_nxt = SEL0;
                    else if (hit1) state_nxt = SEL1;
                    else           state_nxt = ERR;
                end
            end
            SEL0, SEL1: begin
                sel_valid = m_valid;
                m_rdata   = sel_rdata;
                if (!m_valid) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (sel_ready) begin
                    m_ready   = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    // Slave hung: withdraw the request and answer the master ourselves.
                    sel_valid = 1'b0;
                    m_ready   = 1'b1;
                    m_rdata   = ERR_DATA;
                    capture   = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ERR: begin
                m_ready   = 1'b1;
                m_rdata   = ERR_DATA;
                capture   = 1'b1;
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign s0_valid = sel_valid & (state == SEL0);
    assign s1_valid = sel_valid & (state == SEL1);

    // Clear beats capture; only the first error after a clear is recorded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
        end else if (err_clr) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
        end else if (capture && !err_valid) begin
            err_valid <= 1'b1;
            err_addr  <= m_addr;
        end
    end

endmodule

// File: tb/tb_bus_dec1to2.sv
// Bench for bus_dec1to2: directed vector table, hand-written corner sequences,
// then random transactions against a transaction-level reference model.
`timescale 1ns/1ps
module tb_bus_dec1to2;

    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid, m_ready;
    logic [31:0] m_addr, m_rdata, m_wdata;
    logic [3:0]  m_wstrb;
    logic        s0_valid, s0_ready, s1_valid, s1_ready;
    logic [31:0] s0_addr, s0_rdata, s0_wdata, s1_addr, s1_rdata, s1_wdata;
    logic [3:0]  s0_wstrb, s1_wstrb;
    logic        err_valid, err_clr;
    logic [31:0] err_addr;

    always #5 clk = ~clk;

    bus_dec1to2 #(
        .S0_BASE(32'h0000_0000), .S0_MASK(32'hFFFF_0000),
        .S1_BASE(32'h1000_0000), .S1_MASK(32'hF000_0000),
        .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
    ) dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
        .m_rdata(m_rdata), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr),
        .s0_rdata(s0_rdata), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr),
        .s1_rdata(s1_rdata), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
        .err_valid(err_valid), .err_addr(err_addr), .err_clr(err_clr)
    );

    typedef struct {
        logic        mv;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        s0r;
        logic [31:0] s0d;
        logic        s1r;
        logic [31:0] s1d;
        logic        clr;
        logic        e_rdy;
        logic [31:0] e_rdata;
        logic        e_s0v;
        logic        e_s1v;
        logic        e_errv;
        logic [31:0] e_erra;
    } vec_t;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic        model_errv = 1'b0;
    logic [31:0] model_erra = 32'h0;
    vec_t        tbl[$];
    vec_t        v;

    function automatic vec_t vin(input logic [31:0] mv, addr, wd, st, s0r, s0d, s1r, s1d, clr);
        vec_t r;
        r.mv = mv[0]; r.addr = addr; r.wdata = wd; r.strb = st[3:0];
        r.s0r = s0r[0]; r.s0d = s0d; r.s1r = s1r[0]; r.s1d = s1d; r.clr = clr[0];
        r.e_rdy = 1'b0; r.e_rdata = 32'h0; r.e_s0v = 1'b0; r.e_s1v = 1'b0;
        r.e_errv = 1'b0; r.e_erra = 32'h0;
        return r;
    endfunction

    function automatic vec_t mk(input logic [31:0] mv, addr, wd, st, s0r, s0d, s1r, s1d, clr,
                                 rdy, rd, s0v, s1v, ev, ea);
        vec_t r;
        r = vin(mv, addr, wd, st, s0r, s0d, s1r, s1d, clr);
        r.e_rdy = rdy[0]; r.e_rdata = rd; r.e_s0v = s0v[0]; r.e_s1v = s1v[0];
        r.e_errv = ev[0]; r.e_erra = ea;
        return r;
    endfunction

    task automatic applyStimulus(input vec_t x);
        m_valid = x.mv; m_addr = x.addr; m_wdata = x.wdata; m_wstrb = x.strb;
        s0_ready = x.s0r; s0_rdata = x.s0d; s1_ready = x.s1r; s1_rdata = x.s1d;
        err_clr = x.clr;
        #1;
    endtask

    task automatic checkOutput(input string name, input vec_t x);
        logic fwd;
        fwd = (s0_addr === x.addr) && (s1_addr === x.addr) && (s0_wdata === x.wdata) &&
              (s1_wdata === x.wdata) && (s0_wstrb === x.strb) && (s1_wstrb === x.strb);
        n_vec++;
        if (m_ready !== x.e_rdy || m_rdata !== x.e_rdata || s0_valid !== x.e_s0v ||
            s1_valid !== x.e_s1v || err_valid !== x.e_errv || err_addr !== x.e_erra || !fwd) begin
            n_bad++;
            $display("[TB] FAIL %s cycle %0d: got rdy=%b rdata=%h s0v=%b s1v=%b errv=%b erra=%h fwd=%b, want rdy=%b rdata=%h s0v=%b s1v=%b errv=%b erra=%h fwd=1",
                     name, cyc, m_ready, m_rdata, s0_valid, s1_valid, err_valid, err_addr, fwd,
                     x.e_rdy, x.e_rdata, x.e_s0v, x.e_s1v, x.e_errv, x.e_erra);
        end
    endtask

    task automatic runCycle(input string name, input vec_t x);
        applyStimulus(x);
        checkOutput(name, x);
        @(negedge clk);
        cyc++;
    endtask

    // Expected outputs for one cycle plus the sticky error register model.
    task automatic cycleModel(input string name, input vec_t x, input logic rdy,
                              input logic [31:0] rd, input logic s0v, input logic s1v,
                              input logic cap);
        x.e_rdy = rdy; x.e_rdata = rd; x.e_s0v = s0v; x.e_s1v = s1v;
        x.e_errv = model_errv; x.e_erra = model_erra;
        runCycle(name, x);
        if (x.clr) begin
            model_errv = 1'b0;
            model_erra = 32'h0;
        end else if (cap && !model_errv) begin
            model_errv = 1'b1;
            model_erra = x.addr;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          tgt, w, gap, reg_sel;
        logic [31:0] addr, wd, sd, od;
        logic [3:0]  st;
        logic        rdy_now;

        reset = 1'b1;
        applyStimulus(vin(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        runCycle("reset_state", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;

        // Read to slave 0, write to slave 1 with 3 waits, unmapped errors and clears.
        tbl.push_back(mk(1, 32'h10, 0, 0, 1, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h10, 0, 0, 1, 32'h1234_5678, 0, 0, 0, 1, 32'h1234_5678, 1, 0, 0, 0));
        tbl.push_back(mk(0, 32'h10, 0, 0, 1, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h1000_0004, 32'hA5A5_A5A5, 4'hF, 0, 0, 0, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 32'h1000_0004, 32'hA5A5_A5A5, 4'hF, 0, 0, 0, 32'hCAFE_F00D, 0, 0, 32'hCAFE_F00D, 0, 1, 0, 0));
        tbl.push_back(mk(1, 32'h1000_0004, 32'hA5A5_A5A5, 4'hF, 0, 0, 1, 32'hCAFE_F00D, 0, 1, 32'hCAFE_F00D, 0, 1, 0, 0));
        tbl.push_back(mk(0, 32'h1000_0004, 32'hA5A5_A5A5, 4'hF, 0, 0, 0, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h2000_0000, 0, 0, 1, 32'h11, 1, 32'h22, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h2000_0000, 0, 0, 1, 32'h11, 1, 32'h22, 0, 1, ERR_DATA, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h2000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2000_0000));
        tbl.push_back(mk(1, 32'h3000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2000_0000));
        tbl.push_back(mk(1, 32'h3000_0000, 0, 0, 0, 0, 0, 0, 0, 1, ERR_DATA, 0, 0, 1, 32'h2000_0000));
        tbl.push_back(mk(0, 32'h3000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2000_0000));
        tbl.push_back(mk(0, 32'h3000_0000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h2000_0000));
        tbl.push_back(mk(0, 32'h3000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h4000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h4000_0000, 0, 0, 0, 0, 0, 0, 1, 1, ERR_DATA, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h4000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++)
            runCycle($sformatf("table[%0d]", i), tbl[i]);

        // Slave 0 never answers: timeout on the TIMEOUT-th select cycle.
        v = vin(1, 32'h0, 32'h77, 4'h3, 0, 32'h5555_AAAA, 1, 32'h99, 0);
        cycleModel("to_req", v, 0, 0, 0, 0, 0);
        for (int k = 0; k < TIMEOUT; k++) begin
            if (k == TIMEOUT - 1) cycleModel("to_fire", v, 1, ERR_DATA, 0, 0, 1);
            else                  cycleModel("to_wait", v, 0, 32'h5555_AAAA, 1, 0, 0);
        end
        cycleModel("to_err_seen", vin(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0);
        cycleModel("to_clr", vin(0, 0, 0, 0, 0, 0, 0, 0, 1), 0, 0, 0, 0, 0);

        // Ready arrives exactly on the last allowed cycle: normal completion wins.
        v = vin(1, 32'h100, 0, 0, 0, 32'h0BAD_F00D, 0, 0, 0);
        cycleModel("late_req", v, 0, 0, 0, 0, 0);
        for (int k = 0; k < TIMEOUT - 1; k++)
            cycleModel("late_wait", v, 0, 32'h0BAD_F00D, 1, 0, 0);
        v.s0r = 1'b1;
        cycleModel("late_done", v, 1, 32'h0BAD_F00D, 1, 0, 0);
        cycleModel("late_noerr", vin(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0);

        // Master drops valid mid-select: back to idle, no ready, then a clean retry.
        v = vin(1, 32'h20, 0, 0, 0, 32'h4444_0000, 0, 0, 0);
        cycleModel("drop_req", v, 0, 0, 0, 0, 0);
        cycleModel("drop_sel", v, 0, 32'h4444_0000, 1, 0, 0);
        cycleModel("drop_sel", v, 0, 32'h4444_0000, 1, 0, 0);
        v.mv = 1'b0;
        cycleModel("drop_cycle", v, 0, 32'h4444_0000, 0, 0, 0);
        v.mv = 1'b1; v.s0r = 1'b1;
        cycleModel("drop_idle", v, 0, 0, 0, 0, 0);
        cycleModel("drop_retry", v, 1, 32'h4444_0000, 1, 0, 0);

        // Reset while slave 1 is stalling, with an error already captured.
        v = vin(1, 32'h5000_0000, 0, 0, 0, 0, 0, 0, 0);
        cycleModel("pre_err_req", v, 0, 0, 0, 0, 0);
        cycleModel("pre_err", v, 1, ERR_DATA, 0, 0, 1);
        v = vin(1, 32'h1000_0008, 32'h1, 4'h1, 0, 0, 0, 32'h6666_7777, 0);
        cycleModel("rst_req", v, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            cycleModel("rst_sel1", v, 0, 32'h6666_7777, 0, 1, 0);
        applyStimulus(v);
        reset = 1'b1;
        #1;
        checkOutput("rst_async", mk(1, 32'h1000_0008, 32'h1, 4'h1, 0, 0, 0, 32'h6666_7777, 0,
                                    0, 0, 0, 0, 0, 0));
        model_errv = 1'b0;
        model_erra = 32'h0;
        @(negedge clk);
        cyc++;
        reset = 1'b0;
        cycleModel("rst_idle", v, 0, 0, 0, 0, 0);
        v.s1r = 1'b1;
        cycleModel("rst_retry", v, 1, 32'h6666_7777, 0, 1, 0);

        // Random transactions against a transaction-level model.
        for (int t = 0; t < 60; t++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++)
                cycleModel("rand_gap", vin(0, $urandom, $urandom, 0, $urandom_range(0, 1), $urandom,
                           $urandom_range(0, 1), $urandom, ($urandom_range(0, 4) == 0) ? 1 : 0),
                           0, 0, 0, 0, 0);
            reg_sel = $urandom_range(0, 3);
            case (reg_sel)
                0:       addr = {16'h0000, 16'($urandom)};
                1:       addr = {4'h1, 28'($urandom)};
                2:       addr = {4'($urandom_range(2, 15)), 28'($urandom)};
                default: addr = $urandom;
            endcase
            if ((addr >> 16) == 0)      tgt = 0;
            else if ((addr >> 28) == 1) tgt = 1;
            else                        tgt = 2;
            wd = $urandom; st = 4'($urandom); sd = $urandom; od = $urandom;
            w = $urandom_range(0, TIMEOUT + 3);
            v = vin(1, addr, wd, st, $urandom_range(0, 1), sd, $urandom_range(0, 1), od, 0);
            cycleModel("rand_req", v, 0, 0, 0, 0, 0);
            if (tgt == 2) begin
                cycleModel("rand_unmapped", v, 1, ERR_DATA, 0, 0, 1);
            end else begin
                for (int k = 0; k < TIMEOUT; k++) begin
                    rdy_now = (k >= w);
                    if (tgt == 0) begin
                        v.s0r = rdy_now; v.s0d = sd; v.s1r = 1'($urandom); v.s1d = od;
                    end else begin
                        v.s1r = rdy_now; v.s1d = sd; v.s0r = 1'($urandom); v.s0d = od;
                    end
                    if (rdy_now) begin
                        cycleModel("rand_done", v, 1, sd, tgt == 0, tgt == 1, 0);
                        break;
                    end else if (k == TIMEOUT - 1) begin
                        cycleModel("rand_timeout", v, 1, ERR_DATA, 0, 0, 1);
                    end else begin
                        cycleModel("rand_wait", v, 0, sd, tgt == 0, tgt == 1, 0);
                    end
                end
            end
        end
        cycleModel("final_idle", vin(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_dec1to2.md
Name: bus_dec1to2

Overview:
- Downstream stage of the 2-master bus arbiter: takes the single arbitrated master bus and routes it to one of two slave windows.
- Uses the same valid/ready, addr, rdata, wdata, wstrb protocol on all ports.
- Unmapped addresses and hung slaves are terminated locally with an error response, so the master never stalls forever.
- A sticky error-capture register is exposed for debug.

Parameters:
S0_BASE   32'h0000_0000  slave 0 window base
S0_MASK   32'hFFFF_0000  slave 0 compare mask
S1_BASE   32'h1000_0000  slave 1 window base
S1_MASK   32'hF000_0000  slave 1 compare mask
TIMEOUT   16             max cycles a selected slave may hold off ready (>=2)
ERR_DATA  32'hDEAD_BEEF  rdata returned on error termination

Ports:
clk        in   1   clock, rising edge
reset      in   1   asynchronous, active-high reset
m_valid    in   1   master request
m_ready    out  1   transfer complete, one-cycle pulse
m_addr     in   32  master address
m_rdata    out  32  read data to master
m_wdata    in   32  write data
m_wstrb    in   4   byte strobes, 0 = read
s0_valid   out  1   slave 0 request
s0_ready   in   1   slave 0 done
s0_addr    out  32  slave 0 address (m_addr passthrough)
s0_rdata   in   32  slave 0 read data
s0_wdata   out  32  slave 0 write data
s0_wstrb   out  4   slave 0 strobes
s1_*       -    -   identical set for slave 1
err_valid  out  1   sticky: an error termination occurred
err_addr   out  32  address of the first error since last clear
err_clr    in   1   clears err_valid/err_addr (sync)

Behaviour:
- Decode: hit0 = (m_addr & S0_MASK) == S0_BASE; hit1 = likewise for S1. hit0 has priority if both.
- FSM states: IDLE, SEL0, SEL1, ERR. Reset: IDLE, timeout counter 0, err_valid 0, err_addr 0.
- IDLE:
  - All s*_valid = 0, m_ready = 0, m_rdata = 0.
  - On m_valid: go to SEL0 if hit0, else SEL1 if hit1, else ERR.
  - The decode takes one registered cycle; nothing is forwarded in IDLE.
- SELn:
  - sn_valid = m_valid; sn_addr/wdata/wstrb = master fields; the other slave's valid = 0.
  - m_ready = sn_ready & m_valid; m_rdata = sn_rdata.
  - On m_ready: go to IDLE and clear the counter.
  - The counter increments each SELn cycle without ready.
  - When counter == TIMEOUT-1 and sn_ready = 0: drop sn_valid that cycle, m_ready = 1, m_rdata = ERR_DATA, capture the error, go to IDLE.
  - If ready arrives in that same cycle, the normal completion wins.
- ERR: m_ready = 1 for exactly one cycle, m_rdata = ERR_DATA, no slave valid, capture the error, go to IDLE.
- m_valid deasserting in SELn (protocol violation): next state IDLE, counter cleared, no m_ready.
- Error capture: if err_valid = 0, set err_valid = 1 and err_addr = m_addr. Later errors do not overwrite.
- err_clr has priority over capture in the same cycle.
- Latency: minimum 2 cycles from m_valid to m_ready (decode cycle, then a slave with combinational ready). Back-to-back transfers re-enter IDLE between them, so at most one transfer per 2 cycles.
- Slave address/wdata/wstrb are driven from the master in every state; only valid is gated.
- Reset asserted mid-transfer: immediate return to IDLE with all valids and m_ready low. The slave sees valid drop, and the master must reissue.

Test Plan:
1. Read to 0x0000_0010, s0_ready high with s0_rdata = 0x1234_5678 -> s0_valid in cycle 2, m_ready pulses cycle 2 with rdata 0x1234_5678; s1_valid stays 0.
2. Write to 0x1000_0004, wstrb 4'hF, wdata 0xA5A5_A5A5, s1_ready asserted after 3 wait cycles -> s1 sees wdata/wstrb, one m_ready pulse, FSM back in IDLE.
3. Access to unmapped 0x2000_0000 -> m_ready one cycle after request with rdata 0xDEAD_BEEF; err_valid = 1, err_addr = 0x2000_0000; a second error to 0x3000_0000 leaves err_addr unchanged; err_clr clears both.
4. Access to 0x0000_0000 with s0_ready held low -> m_ready with 0xDEAD_BEEF exactly TIMEOUT (16) cycles after SEL0 entry; s0_valid low that cycle; err_valid set.
5. s0_ready rises on the cycle the counter hits TIMEOUT-1 -> normal completion with s0_rdata, no error captured.
6. Reset pulsed while in SEL1 awaiting ready -> s1_valid and m_ready drop immediately, FSM IDLE, err regs 0; master m_valid dropped mid-SEL0 -> IDLE with no m_ready.
